// File: rtl/deglitch_sync_filter.sv
// rtl/deglitch_sync_filter.sv - multi-channel synchronizer plus counting deglitch filter
module deglitch_sync_filter #(
    parameter int             CH       = 2,
    parameter int             CNT_W    = 4,
    parameter int             SYNC_STG = 2,
    parameter logic [CH-1:0]  RST_VAL  = {CH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CH-1:0]    din,
    input  logic [CH-1:0]    byp,
    input  logic [CNT_W-1:0] thresh,
    output logic [CH-1:0]    dout,
    output logic [CH-1:0]    rise,
    output logic [CH-1:0]    fall,
    output logic [CH-1:0]    glitch
);

    for (genvar g = 0; g < CH; g++) begin : g_ch
        logic [SYNC_STG-1:0] r_sync;
        logic [CNT_W-1:0]    r_cnt;
        logic                r_dout;
        logic                r_rise;
        logic                r_fall;
        logic                r_glitch;
        logic                w_sync;
        logic                w_diff;
        logic                w_next;

        assign w_sync = r_sync[SYNC_STG-1];
        assign w_diff = (w_sync != r_dout);

        // >= rather than == so a lowered thresh flips on the next differing cycle
        always_comb begin
            w_next = r_dout;
            if (byp[g])
                w_next = w_sync;
            else if (w_diff && (r_cnt >= thresh))
                w_next = w_sync;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_sync   <= {SYNC_STG{RST_VAL[g]}};
                r_dout   <= RST_VAL[g];
                r_cnt    <= '0;
                r_rise   <= 1'b0;
                r_fall   <= 1'b0;
                r_glitch <= 1'b0;
            end else begin
                r_sync <= {r_sync[SYNC_STG-2:0], din[g]};
                r_dout <= w_next;
                r_rise <= w_next & ~r_dout;
                r_fall <= ~w_next & r_dout;
                if (byp[g]) begin
                    r_cnt    <= '0;
                    r_glitch <= 1'b0;
                end else if (!w_diff) begin
                    r_cnt    <= '0;
                    r_glitch <= (r_cnt != '0);
                end else if (r_cnt >= thresh) begin
                    r_cnt    <= '0;
                    r_glitch <= 1'b0;
                end else begin
                    r_cnt    <= r_cnt + CNT_W'(1);
                    r_glitch <= 1'b0;
                end
            end
        end

        assign dout[g]   = r_dout;
        assign rise[g]   = r_rise;
        assign fall[g]   = r_fall;
        assign glitch[g] = r_glitch;
    end

endmodule

// File: tb/tb_deglitch_sync_filter.sv
// tb/tb_deglitch_sync_filter.sv - directed self-checking bench for deglitch_sync_filter
module tb_deglitch_sync_filter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] din;
    logic [1:0] byp;
    logic [3:0] thresh;
    logic [1:0] dout;
    logic [1:0] rise;
    logic [1:0] fall;
    logic [1:0] glitch;

    int n_checks = 0;
    int n_fail   = 0;

    deglitch_sync_filter #(
        .CH(2), .CNT_W(4), .SYNC_STG(2), .RST_VAL(2'b11)
    ) dut (
        .clk(clk), .rst(rst), .din(din), .byp(byp), .thresh(thresh),
        .dout(dout), .rise(rise), .fall(fall), .glitch(glitch)
    );

    always #5 clk = ~clk;

    // inputs change and outputs are sampled 1ns after each rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; din = 2'b11; byp = 2'b00; thresh = 4'd3;
        idle(3);
        rst = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            n_checks++;
            if ({dout, rise, fall, glitch} !== 8'b11_00_00_00) begin
                n_fail++;
                $display("FAIL reset_idle cyc=%0d got dout=%b rise=%b fall=%b glitch=%b want 11/00/00/00",
                         i, dout, rise, fall, glitch);
            end
        end
    endtask

    task automatic test_fall_latency();
        logic [1:0] e_dout, e_fall;
        din = 2'b10;
        for (int i = 1; i <= 8; i++) begin
            tick();
            e_dout = (i >= 6) ? 2'b10 : 2'b11;
            e_fall = (i == 6) ? 2'b01 : 2'b00;
            n_checks++;
            if (dout !== e_dout || fall !== e_fall || rise !== 2'b00 || glitch !== 2'b00) begin
                n_fail++;
                $display("FAIL fall_latency cyc=%0d got dout=%b fall=%b rise=%b glitch=%b want dout=%b fall=%b",
                         i, dout, fall, rise, glitch, e_dout, e_fall);
            end
        end
        din = 2'b11;
        idle(10);
        n_checks++;
        if (dout !== 2'b11) begin
            n_fail++;
            $display("FAIL fall_restore got dout=%b want 11", dout);
        end
    endtask

    task automatic test_glitch_reject();
        logic e_g;
        din = 2'b10;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 3) din = 2'b11;
            e_g = (i == 6);
            n_checks++;
            if (dout !== 2'b11 || glitch[0] !== e_g || rise !== 2'b00 || fall !== 2'b00) begin
                n_fail++;
                $display("FAIL glitch3 cyc=%0d got dout=%b glitch=%b rise=%b fall=%b want dout=11 glitch0=%b",
                         i, dout, glitch, rise, fall, e_g);
            end
        end
    endtask

    task automatic test_pulse_pass();
        logic e_d, e_r, e_f;
        din = 2'b10;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (i == 4) din = 2'b11;
            e_d = !(i >= 6 && i <= 9);
            e_f = (i == 6);
            e_r = (i == 10);
            n_checks++;
            if (dout[0] !== e_d || fall[0] !== e_f || rise[0] !== e_r || glitch !== 2'b00 || dout[1] !== 1'b1) begin
                n_fail++;
                $display("FAIL pulse4 cyc=%0d got dout=%b rise=%b fall=%b glitch=%b want d0=%b r0=%b f0=%b",
                         i, dout, rise, fall, glitch, e_d, e_r, e_f);
            end
        end
    endtask

    task automatic test_bypass();
        logic e_d, e_r, e_f;
        byp = 2'b01;
        idle(2);
        din = 2'b10;
        for (int i = 1; i <= 7; i++) begin
            tick();
            if (i == 1) din = 2'b11;
            e_d = (i != 3);
            e_f = (i == 3);
            e_r = (i == 4);
            n_checks++;
            if (dout[0] !== e_d || fall[0] !== e_f || rise[0] !== e_r || glitch !== 2'b00) begin
                n_fail++;
                $display("FAIL bypass cyc=%0d got dout=%b rise=%b fall=%b glitch=%b want d0=%b r0=%b f0=%b",
                         i, dout, rise, fall, glitch, e_d, e_r, e_f);
            end
        end
        byp = 2'b00;
        idle(3);
    endtask

    task automatic test_thresh_zero();
        logic e_d, e_r, e_f;
        thresh = 4'd0;
        idle(2);
        din = 2'b10;
        for (int i = 1; i <= 7; i++) begin
            tick();
            if (i == 1) din = 2'b11;
            e_d = (i != 3);
            e_f = (i == 3);
            e_r = (i == 4);
            n_checks++;
            if (dout[0] !== e_d || fall[0] !== e_f || rise[0] !== e_r || glitch !== 2'b00) begin
                n_fail++;
                $display("FAIL thresh0 cyc=%0d got dout=%b rise=%b fall=%b glitch=%b want d0=%b r0=%b f0=%b",
                         i, dout, rise, fall, glitch, e_d, e_r, e_f);
            end
        end
    endtask

    task automatic test_thresh_max();
        logic e_d, e_r, e_f, e_g;
        thresh = 4'd15;
        idle(3);
        din = 2'b10;
        for (int i = 1; i <= 22; i++) begin
            tick();
            if (i == 15) din = 2'b11;
            e_g = (i == 18);
            n_checks++;
            if (dout !== 2'b11 || glitch[0] !== e_g || rise !== 2'b00 || fall !== 2'b00) begin
                n_fail++;
                $display("FAIL thresh15_reject cyc=%0d got dout=%b glitch=%b rise=%b fall=%b want dout=11 glitch0=%b",
                         i, dout, glitch, rise, fall, e_g);
            end
        end
        din = 2'b10;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 16) din = 2'b11;
            e_d = !(i >= 18 && i <= 33);
            e_f = (i == 18);
            e_r = (i == 34);
            n_checks++;
            if (dout[0] !== e_d || fall[0] !== e_f || rise[0] !== e_r || glitch !== 2'b00) begin
                n_fail++;
                $display("FAIL thresh15_pass cyc=%0d got dout=%b rise=%b fall=%b glitch=%b want d0=%b r0=%b f0=%b",
                         i, dout, rise, fall, glitch, e_d, e_r, e_f);
            end
        end
        thresh = 4'd3;
        idle(3);
    endtask

    task automatic test_parallel();
        logic [1:0] e_d, e_f, e_g;
        din = 2'b00;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 3) din = 2'b10;
            e_d = (i >= 6) ? 2'b10 : 2'b11;
            e_f = (i == 6) ? 2'b01 : 2'b00;
            e_g = (i == 6) ? 2'b10 : 2'b00;
            n_checks++;
            if (dout !== e_d || fall !== e_f || glitch !== e_g || rise !== 2'b00) begin
                n_fail++;
                $display("FAIL parallel cyc=%0d got dout=%b fall=%b glitch=%b rise=%b want dout=%b fall=%b glitch=%b",
                         i, dout, fall, glitch, rise, e_d, e_f, e_g);
            end
        end
        din = 2'b11;
        idle(10);
    endtask

    task automatic test_reset_mid();
        logic [1:0] e_d, e_f;
        din = 2'b10;
        idle(4);
        rst = 1'b1;
        din = 2'b11;
        tick();
        n_checks++;
        if ({dout, rise, fall, glitch} !== 8'b11_00_00_00) begin
            n_fail++;
            $display("FAIL reset_mid got dout=%b rise=%b fall=%b glitch=%b want 11/00/00/00",
                     dout, rise, fall, glitch);
        end
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_checks++;
            if ({dout, rise, fall, glitch} !== 8'b11_00_00_00) begin
                n_fail++;
                $display("FAIL reset_release cyc=%0d got dout=%b rise=%b fall=%b glitch=%b want 11/00/00/00",
                         i, dout, rise, fall, glitch);
            end
        end
        din = 2'b10;
        for (int i = 1; i <= 7; i++) begin
            tick();
            e_d = (i >= 6) ? 2'b10 : 2'b11;
            e_f = (i == 6) ? 2'b01 : 2'b00;
            n_checks++;
            if (dout !== e_d || fall !== e_f || glitch !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_refilter cyc=%0d got dout=%b fall=%b glitch=%b want dout=%b fall=%b",
                         i, dout, fall, glitch, e_d, e_f);
            end
        end
    endtask

    initial begin
        rst = 1'b1; din = 2'b11; byp = 2'b00; thresh = 4'd3;
        test_reset();
        test_fall_latency();
        test_glitch_reject();
        test_pulse_pass();
        test_bypass();
        test_thresh_zero();
        test_thresh_max();
        test_parallel();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
